// File: rtl/pc_update_unit.sv
// ============================================================================
// Module      : pc_update_unit
// Description : PC/EPC holding stage with branch-condition commit and the
//               exception-entry sequence (EPC save, vector fetch, PC load).
//               Optional misaligned-PC exception: define PC_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_update_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 1,
  parameter logic [7:0]  VEC_OPCODE  = 8'd253,
  parameter logic [7:0]  VEC_OVF     = 8'd254,
  parameter logic [7:0]  VEC_DIV0    = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        zero,
  input  logic        gt,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] mem_addr,
  output logic        mem_rd_req,
  output logic        busy,
`ifdef PC_ALIGN_CHECK_EN
  output logic [2:0]  exc_cause
`else
  output logic [1:0]  exc_cause
`endif
);

`ifdef PC_ALIGN_CHECK_EN
  localparam int c_CAUSE_W = 3;
`else
  localparam int c_CAUSE_W = 2;
`endif

  localparam logic [c_CAUSE_W-1:0] c_CAUSE_NONE   = c_CAUSE_W'(0);
  localparam logic [c_CAUSE_W-1:0] c_CAUSE_OPCODE = c_CAUSE_W'(1);
  localparam logic [c_CAUSE_W-1:0] c_CAUSE_OVF    = c_CAUSE_W'(2);
  localparam logic [c_CAUSE_W-1:0] c_CAUSE_DIV0   = c_CAUSE_W'(3);
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [c_CAUSE_W-1:0] c_CAUSE_ALIGN  = c_CAUSE_W'(4);
  localparam logic [7:0]           c_VEC_ALIGN    = 8'd252;
`endif

  // Counter only needs to hold MEM_LATENCY-1
  localparam int                   c_CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [c_CNT_W-1:0]   c_CNT_INIT = c_CNT_W'(MEM_LATENCY - 1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]   c_CNT_ZERO = c_CNT_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_pc;
  logic [31:0]            r_epc;
  logic [31:0]            r_mem_addr;
  logic [c_CAUSE_W-1:0]   r_cause;
  logic [c_CNT_W-1:0]     r_cnt;

  logic                   w_cond;
  logic                   w_take;
  logic                   w_exc;
  logic [c_CAUSE_W-1:0]   w_cause;
  logic [7:0]             w_vec;
  logic [7:0]             w_byte;
  logic                   w_busy;
  logic                   w_rd_req;

  always_comb begin
    w_cond = 1'b0;
    case (branch_op)
      2'd0:    w_cond = zero;
      2'd1:    w_cond = ~zero;
      2'd2:    w_cond = ~gt;
      default: w_cond = gt;
    endcase
  end

  assign w_take = pc_write | (pc_write_cond & w_cond);

  // Fixed priority: opcode > ovf > div0 (> misalignment when enabled)
  always_comb begin
    w_exc   = 1'b0;
    w_cause = c_CAUSE_NONE;
    w_vec   = 8'd0;
    if (exc_opcode) begin
      w_exc   = 1'b1;
      w_cause = c_CAUSE_OPCODE;
      w_vec   = VEC_OPCODE;
    end else if (exc_ovf) begin
      w_exc   = 1'b1;
      w_cause = c_CAUSE_OVF;
      w_vec   = VEC_OVF;
    end else if (exc_div0) begin
      w_exc   = 1'b1;
      w_cause = c_CAUSE_DIV0;
      w_vec   = VEC_DIV0;
    end
`ifdef PC_ALIGN_CHECK_EN
    else if (w_take && (pc_next[1:0] != 2'b00)) begin
      w_exc   = 1'b1;
      w_cause = c_CAUSE_ALIGN;
      w_vec   = c_VEC_ALIGN;
    end
`endif
  end

  // Little-endian lane select of the handler byte
  always_comb begin
    w_byte = 8'd0;
    case (r_mem_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_rd_req    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_exc) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_busy      = 1'b1;
        w_rd_req    = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        if (r_cnt == c_CNT_ZERO) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_epc      <= 32'd0;
      r_mem_addr <= 32'd0;
      r_cause    <= c_CAUSE_NONE;
      r_cnt      <= c_CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // An exception suppresses any PC commit on the same edge
          if (w_exc) begin
            r_epc      <= r_pc - 32'd4;
            r_cause    <= w_cause;
            r_mem_addr <= {24'b0, w_vec};
          end else if (w_take) begin
            r_pc <= pc_next;
          end
        end
        ST_REQ: begin
          r_cnt <= c_CNT_INIT;
        end
        ST_WAIT: begin
          if (r_cnt == c_CNT_ZERO) begin
            r_pc <= {24'b0, w_byte};
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        default: begin
          r_cnt <= c_CNT_ZERO;
        end
      endcase
    end
  end

  assign pc         = r_pc;
  assign epc        = r_epc;
  assign mem_addr   = r_mem_addr;
  assign exc_cause  = r_cause;
  assign busy       = w_busy;
  assign mem_rd_req = w_rd_req;

endmodule

`default_nettype wire

// File: tb/tb_pc_update_unit.sv
// ============================================================================
// Module      : tb_pc_update_unit
// Description : Directed self-checking bench for pc_update_unit (latency 1
//               and latency 3 instances driven from shared inputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_update_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        zero;
  logic        gt;
  logic        exc_opcode;
  logic        exc_ovf;
  logic        exc_div0;
  logic [31:0] mem_rdata;

  logic [31:0] pc, epc, mem_addr;
  logic        mem_rd_req, busy;
  logic [31:0] pc3, epc3, mem_addr3;
  logic        mem_rd_req3, busy3;
`ifdef PC_ALIGN_CHECK_EN
  logic [2:0]  exc_cause, exc_cause3;
`else
  logic [1:0]  exc_cause, exc_cause3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  pc_update_unit #(.MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .zero(zero), .gt(gt),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .mem_rdata(mem_rdata), .pc(pc), .epc(epc), .mem_addr(mem_addr),
    .mem_rd_req(mem_rd_req), .busy(busy), .exc_cause(exc_cause)
  );

  pc_update_unit #(.MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .branch_op(branch_op), .zero(zero), .gt(gt),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .mem_rdata(mem_rdata), .pc(pc3), .epc(epc3), .mem_addr(mem_addr3),
    .mem_rd_req(mem_rd_req3), .busy(busy3), .exc_cause(exc_cause3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; branch_op = 0; zero = 0; gt = 0;
    exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; mem_rdata = 0; pc_next = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_write = 1; pc_next = v;
    tick();
    pc_write = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc); end
    n_cmp++; if (epc !== 32'h0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_epc_addr: got %h/%h want 0/0", epc, mem_addr); end
    n_cmp++; if (busy !== 1'b0 || mem_rd_req !== 1'b0 || exc_cause !== 0) begin n_fail++; $display("FAIL reset_ctl: got busy=%b req=%b cause=%0d want 0/0/0", busy, mem_rd_req, exc_cause); end
  endtask

  task automatic test_reset_mid_wait();
    int reqs;
    do_reset();
    exc_ovf = 1;
    tick();
    exc_ovf = 0;
    n_cmp++; if (epc !== 32'hFFFF_FFFC || exc_cause !== 2 || mem_rd_req !== 1'b1) begin n_fail++; $display("FAIL ovf_entry_wrap: got epc=%h cause=%0d req=%b want fffffffc/2/1", epc, exc_cause, mem_rd_req); end
    mem_rdata = 32'h5555_5555;
    tick();
    n_cmp++; if (busy !== 1'b1 || mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL wait_state: got busy=%b req=%b want 1/0", busy, mem_rd_req); end
    reset = 1;
    tick();
    reset = 0;
    mem_rdata = 0;
    n_cmp++; if (pc !== 32'h0 || busy !== 1'b0 || epc !== 32'h0 || exc_cause !== 0) begin n_fail++; $display("FAIL reset_mid_wait: got pc=%h busy=%b epc=%h cause=%0d want 0/0/0/0", pc, busy, epc, exc_cause); end
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rd_req === 1'b1) reqs++;
      tick();
    end
    n_cmp++; if (reqs !== 0) begin n_fail++; $display("FAIL no_req_after_reset: got %0d strobes want 0", reqs); end
  endtask

  task automatic test_write_branch();
    do_reset();
    set_pc(32'h100);
    pc_write = 1; pc_next = 32'h104;
    tick();
    pc_write = 0;
    n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL pc_write: got %h want 00000104", pc); end
    pc_write_cond = 1; branch_op = 0; zero = 0; pc_next = 32'h200;
    tick();
    n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL beq_not_taken: got %h want 00000104", pc); end
    zero = 1;
    tick();
    pc_write_cond = 0; zero = 0;
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL beq_taken: got %h want 00000200", pc); end
    pc_next = 32'h300;
    tick();
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL no_write_hold: got %h want 00000200", pc); end
  endtask

  task automatic test_branch_sweep();
    do_reset();
    set_pc(32'h200);
    pc_write_cond = 1; pc_next = 32'h40; branch_op = 1; zero = 1;
    tick();
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL bne_zero1: got %h want 00000200", pc); end
    branch_op = 2; zero = 0; gt = 0;
    tick();
    n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL ble_gt0: got %h want 00000040", pc); end
    pc_write_cond = 0;
    set_pc(32'h200);
    pc_write_cond = 1; pc_next = 32'h40; branch_op = 3; gt = 0;
    tick();
    n_cmp++; if (pc !== 32'h200) begin n_fail++; $display("FAIL bgt_gt0: got %h want 00000200", pc); end
    gt = 1;
    tick();
    pc_write_cond = 0; gt = 0;
    n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL bgt_gt1: got %h want 00000040", pc); end
  endtask

  task automatic test_exception_priority();
    do_reset();
    set_pc(32'h24);
    exc_div0 = 1; exc_ovf = 1; pc_write = 1; pc_next = 32'h999;
    tick();
    exc_div0 = 0; exc_ovf = 0;
    n_cmp++; if (epc !== 32'h20 || exc_cause !== 2 || mem_addr !== 32'd254) begin n_fail++; $display("FAIL prio_entry: got epc=%h cause=%0d addr=%0d want 20/2/254", epc, exc_cause, mem_addr); end
    n_cmp++; if (mem_rd_req !== 1'b1 || busy !== 1'b1 || pc !== 32'h24) begin n_fail++; $display("FAIL prio_req: got req=%b busy=%b pc=%h want 1/1/00000024", mem_rd_req, busy, pc); end
    mem_rdata = 32'h00AB_0000;
    tick();
    n_cmp++; if (mem_rd_req !== 1'b0 || busy !== 1'b1 || pc !== 32'h24) begin n_fail++; $display("FAIL prio_wait: got req=%b busy=%b pc=%h want 0/1/00000024", mem_rd_req, busy, pc); end
    tick();
    pc_write = 0; mem_rdata = 0;
    n_cmp++; if (pc !== 32'h0000_00AB || busy !== 1'b0) begin n_fail++; $display("FAIL prio_handler: got pc=%h busy=%b want 000000ab/0", pc, busy); end
    n_cmp++; if (epc !== 32'h20 || exc_cause !== 2 || mem_addr !== 32'd254) begin n_fail++; $display("FAIL prio_hold: got epc=%h cause=%0d addr=%0d want 20/2/254", epc, exc_cause, mem_addr); end
  endtask

  task automatic test_back_to_back();
    // div0 alone right after a return; handler byte in lane 3
    exc_div0 = 1;
    tick();
    exc_div0 = 0;
    n_cmp++; if (epc !== 32'hA7 || exc_cause !== 3 || mem_addr !== 32'd255) begin n_fail++; $display("FAIL div0_entry: got epc=%h cause=%0d addr=%0d want a7/3/255", epc, exc_cause, mem_addr); end
    mem_rdata = 32'hCD00_0000;
    tick();
    tick();
    mem_rdata = 0;
    n_cmp++; if (pc !== 32'hCD || busy !== 1'b0) begin n_fail++; $display("FAIL div0_handler: got pc=%h busy=%b want 000000cd/0", pc, busy); end
  endtask

  task automatic test_latency3();
    int busy_cycles;
    do_reset();
    exc_opcode = 1;
    tick();
    exc_opcode = 0;
    n_cmp++; if (exc_cause3 !== 1 || mem_addr3 !== 32'd253 || mem_rd_req3 !== 1'b1) begin n_fail++; $display("FAIL lat3_entry: got cause=%0d addr=%0d req=%b want 1/253/1", exc_cause3, mem_addr3, mem_rd_req3); end
    busy_cycles = 0;
    mem_rdata = 32'h0000_1100;
    for (int i = 0; i < 6; i++) begin
      if (busy3 === 1'b1) busy_cycles++;
      exc_ovf = (i == 0 || i == 1);
      mem_rdata = (i == 3) ? 32'h0000_7C00 : 32'h0000_1100;
      tick();
      if (i == 3) begin
        mem_rdata = 0;
        n_cmp++; if (pc3 !== 32'h7C || busy3 !== 1'b0) begin n_fail++; $display("FAIL lat3_handler: got pc=%h busy=%b want 0000007c/0", pc3, busy3); end
      end
    end
    exc_ovf = 0;
    n_cmp++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL lat3_busy_len: got %0d want 4", busy_cycles); end
    // ovf sampled while busy must not have retriggered or overwritten cause
    n_cmp++; if (exc_cause3 !== 1 || busy3 !== 1'b0) begin n_fail++; $display("FAIL lat3_ovf_ignored: got cause=%0d busy=%b want 1/0", exc_cause3, busy3); end
  endtask

  task automatic test_alignment();
    int saw_bad;
    do_reset();
    set_pc(32'h50);
    pc_write = 1; pc_next = 32'h62;
    tick();
    pc_write = 0;
`ifdef PC_ALIGN_CHECK_EN
    n_cmp++; if (exc_cause !== 4 || epc !== 32'h4C || mem_addr !== 32'd252) begin n_fail++; $display("FAIL align_entry: got cause=%0d epc=%h addr=%0d want 4/4c/252", exc_cause, epc, mem_addr); end
    saw_bad = (pc === 32'h62) ? 1 : 0;
    mem_rdata = 32'h0000_00AA;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pc === 32'h62) saw_bad++;
    end
    mem_rdata = 0;
    n_cmp++; if (saw_bad !== 0 || pc !== 32'hAA) begin n_fail++; $display("FAIL align_handler: got pc=%h bad_seen=%0d want 000000aa/0", pc, saw_bad); end
`else
    saw_bad = 0;
    n_cmp++; if (pc !== 32'h62 || busy !== 1'b0 || exc_cause !== 0 || saw_bad !== 0) begin n_fail++; $display("FAIL misaligned_load: got pc=%h busy=%b cause=%0d want 00000062/0/0", pc, busy, exc_cause); end
`endif
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_reset_mid_wait();
    test_write_branch();
    test_branch_sweep();
    test_exception_priority();
    test_back_to_back();
    test_latency3();
    test_alignment();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
